// File: rtl/dp_prio_bram_pkg.sv
// Shared constants and the byte-merge helper for the dp_prio_bram dual-port RAM.
package dp_prio_bram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  localparam int PRIO_A = 0;
  localparam int PRIO_B = 1;

  // Merge helper works on a wide carrier word; callers size-cast in and out.
  localparam int MAX_W    = 1024;
  localparam int MAX_W_LG = 10;
  typedef logic [MAX_W-1:0] mword_t;

  typedef enum logic {ST_CLEAR, ST_RUN} clr_state_e;

  // Bit i takes new_w where its byte's enable is set, old_w otherwise.
  function automatic mword_t be_merge(mword_t old_w, mword_t new_w, mword_t be_w, int byte_w);
    mword_t r;
    for (int i = 0; i < MAX_W; i++)
      r[i] = be_w[MAX_W_LG'(i / byte_w)] ? new_w[i] : old_w[i];
    return r;
  endfunction

endpackage

// File: rtl/dp_prio_bram_port.sv
// Per-port read path: read-during-write select, accept gating, read pipeline with valid strobe.
module dp_prio_bram_port
  import dp_prio_bram_pkg::*;
#(
  parameter int WIDTH     = 72,
  parameter int RDW       = 0,
  parameter int CROSS_NEW = 0,
  parameter int OUT_REG   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             rden_i,
  input  logic             wren_i,
  input  logic [WIDTH-1:0] old_i,
  input  logic [WIDTH-1:0] fin_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rvalid_o
);

  localparam int STAGES = 1 + OUT_REG;

  logic                          acc;
  logic [WIDTH-1:0]              word;
  logic [STAGES-1:0]             vld_q;
  logic [STAGES-1:0][WIDTH-1:0]  dat_q;

  assign acc = run_i & rden_i & ~(wren_i && (RDW == RDW_NO_CHANGE));

  // fin_i is the word stored after this edge, including the other port's bytes.
  always_comb begin
    word = old_i;
    if (wren_i) begin
      if (RDW == RDW_WRITE_FIRST) word = fin_i;
    end else if (CROSS_NEW != 0) begin
      word = fin_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= acc;
      if (acc) dat_q[0] <= word;
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
      end
    end
  end

  assign rdata_o  = dat_q[STAGES-1];
  assign rvalid_o = vld_q[STAGES-1];

endmodule

// File: rtl/dp_prio_bram.sv
// True dual-port RAM with write priority, per-port RDW modes, byte enables and collision flag.
// Optional power-up zero sweep enabled by DP_PRIO_BRAM_MEM_CLEAR_EN.
module dp_prio_bram
  import dp_prio_bram_pkg::*;
#(
  parameter int ABITS     = 12,
  parameter int WIDTH     = 72,
  parameter int BYTE_W    = 8,
  parameter int PRIORITY  = 1,
  parameter int RDW_A     = 0,
  parameter int RDW_B     = 1,
  parameter int CROSS_NEW = 0,
  parameter int OUT_REG   = 0,
  localparam int NBE      = WIDTH / BYTE_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic             busy,
  input  logic             wren_a,
  input  logic             rden_a,
  input  logic [ABITS-1:0] addr_a,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic [NBE-1:0]   be_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             rvalid_a,
  input  logic             wren_b,
  input  logic             rden_b,
  input  logic [ABITS-1:0] addr_b,
  input  logic [WIDTH-1:0] wdata_b,
  input  logic [NBE-1:0]   be_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_b,
  output logic             collision
);

  localparam int DEPTH = 2 ** ABITS;

  function automatic logic [WIDTH-1:0] mrg(logic [WIDTH-1:0] o, logic [WIDTH-1:0] n,
                                           logic [NBE-1:0] b);
    return WIDTH'(be_merge(MAX_W'(o), MAX_W'(n), MAX_W'(b), BYTE_W));
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             run, we_a, we_b, same, collision_q;
  logic             clr_we;
  logic [ABITS-1:0] clr_addr;
  logic [WIDTH-1:0] old_a, old_b, fin_a, fin_b;
  logic [NBE-1:0]   be_aa, be_ba, be_ab, be_bb;

`ifdef DP_PRIO_BRAM_MEM_CLEAR_EN
  clr_state_e       state_q, state_d;
  logic [ABITS-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    if (state_q == ST_CLEAR && !rst) begin
      clr_we     = 1'b1;
      clr_addr_d = clr_addr_q + 1'b1;
      if (&clr_addr_q) state_d = ST_RUN;
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_addr = clr_addr_q;
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  assign run   = ~busy;
  assign we_a  = wren_a & run;
  assign we_b  = wren_b & run;
  assign same  = (addr_a == addr_b);
  assign old_a = mem_q[addr_a];
  assign old_b = mem_q[addr_b];

  // Effective byte enables landing on each port's address this cycle.
  assign be_aa = we_a ? be_a : '0;
  assign be_ba = (we_b && same) ? be_b : '0;
  assign be_ab = (we_a && same) ? be_a : '0;
  assign be_bb = we_b ? be_b : '0;

  // Loser merged first, winner on top: winner's enabled bytes always prevail.
  always_comb begin
    if (PRIORITY == PRIO_B) begin
      fin_a = mrg(mrg(old_a, wdata_a, be_aa), wdata_b, be_ba);
      fin_b = mrg(mrg(old_b, wdata_a, be_ab), wdata_b, be_bb);
    end else begin
      fin_a = mrg(mrg(old_a, wdata_b, be_ba), wdata_a, be_aa);
      fin_b = mrg(mrg(old_b, wdata_b, be_bb), wdata_a, be_ab);
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (we_a) mem_q[addr_a] <= fin_a;
      if (we_b) mem_q[addr_b] <= fin_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) collision_q <= 1'b0;
    else     collision_q <= we_a & we_b & same;
  end
  assign collision = collision_q;

  dp_prio_bram_port #(.WIDTH(WIDTH), .RDW(RDW_A), .CROSS_NEW(CROSS_NEW), .OUT_REG(OUT_REG)) u_port_a (
    .clk(clk), .rst(rst), .run_i(run), .rden_i(rden_a), .wren_i(wren_a),
    .old_i(old_a), .fin_i(fin_a), .rdata_o(rdata_a), .rvalid_o(rvalid_a)
  );

  dp_prio_bram_port #(.WIDTH(WIDTH), .RDW(RDW_B), .CROSS_NEW(CROSS_NEW), .OUT_REG(OUT_REG)) u_port_b (
    .clk(clk), .rst(rst), .run_i(run), .rden_i(rden_b), .wren_i(wren_b),
    .old_i(old_b), .fin_i(fin_b), .rdata_o(rdata_b), .rvalid_o(rvalid_b)
  );

endmodule

// File: tb/tb_dp_prio_bram.sv
// Scoreboard bench for dp_prio_bram: default instance plus OUT_REG/no-change/cross-new instance.
module tb_dp_prio_bram;
  localparam int AW = 4, W = 72, NB = 9;
`ifdef DP_PRIO_BRAM_MEM_CLEAR_EN
  localparam int EXP_BUSY = 16;
`else
  localparam int EXP_BUSY = 0;
`endif

  typedef struct packed {
    logic          wren;
    logic          rden;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [NB-1:0] be;
  } req_t;
  typedef struct {
    logic [W-1:0] d;
    int           due;
  } exp_t;

  localparam logic [W-1:0] C11 = {9{8'h11}};
  localparam logic [W-1:0] CAA = {9{8'hAA}};
  localparam logic [W-1:0] CBB = {9{8'hBB}};
  localparam logic [W-1:0] C99 = {9{8'h99}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  req_t ra0, rb0, ra1, rb1;
  logic [W-1:0] rda0, rdb0, rda1, rdb1;
  logic rva0, rvb0, rva1, rvb1, busy0, busy1, col0, col1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  exp_t q0a[$], q0b[$], q1a[$], q1b[$];

  dp_prio_bram #(.ABITS(AW)) u0 (
    .clk(clk), .rst(rst), .busy(busy0),
    .wren_a(ra0.wren), .rden_a(ra0.rden), .addr_a(ra0.addr), .wdata_a(ra0.wdata), .be_a(ra0.be),
    .rdata_a(rda0), .rvalid_a(rva0),
    .wren_b(rb0.wren), .rden_b(rb0.rden), .addr_b(rb0.addr), .wdata_b(rb0.wdata), .be_b(rb0.be),
    .rdata_b(rdb0), .rvalid_b(rvb0), .collision(col0)
  );

  dp_prio_bram #(.ABITS(AW), .RDW_B(2), .CROSS_NEW(1), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst), .busy(busy1),
    .wren_a(ra1.wren), .rden_a(ra1.rden), .addr_a(ra1.addr), .wdata_a(ra1.wdata), .be_a(ra1.be),
    .rdata_a(rda1), .rvalid_a(rva1),
    .wren_b(rb1.wren), .rden_b(rb1.rden), .addr_b(rb1.addr), .wdata_b(rb1.wdata), .be_b(rb1.be),
    .rdata_b(rdb1), .rvalid_b(rvb1), .collision(col1)
  );

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push(int s, logic [W-1:0] d);
    exp_t e;
    e.d   = d;
    e.due = cyc + ((s < 2) ? 1 : 2);
    case (s)
      0: q0a.push_back(e);
      1: q0b.push_back(e);
      2: q1a.push_back(e);
      default: q1b.push_back(e);
    endcase
  endtask

  function automatic req_t mk(logic wr, logic rd, logic [AW-1:0] a, logic [W-1:0] d, logic [NB-1:0] be);
    return '{wren: wr, rden: rd, addr: a, wdata: d, be: be};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    ra0 = '0; rb0 = '0; ra1 = '0; rb1 = '0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (busy0) n++;
      else break;
    end
  endtask

  // Monitor: every rvalid pops the matching stream and checks data and arrival cycle.
  always @(negedge clk) begin
    logic v;
    logic [W-1:0] d;
    exp_t e;
    int n;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin v = rva0; d = rda0; n = q0a.size(); end
        1: begin v = rvb0; d = rdb0; n = q0b.size(); end
        2: begin v = rva1; d = rda1; n = q1a.size(); end
        default: begin v = rvb1; d = rdb1; n = q1b.size(); end
      endcase
      if (v) begin
        if (n == 0) begin
          chk($sformatf("rd%0d_unexpected_rvalid", s), 1, 0);
        end else begin
          case (s)
            0: e = q0a.pop_front();
            1: e = q0b.pop_front();
            2: e = q1a.pop_front();
            default: e = q1b.pop_front();
          endcase
          chk($sformatf("rd%0d_data_cycle", s), {d, 32'(cyc)}, {e.d, 32'(e.due)});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    ra0 = '0; rb0 = '0; ra1 = '0; rb1 = '0;
    repeat (3) step();
    chk("rst_rdata_a0", rda0, 0);
    chk("rst_rdata_b0", rdb0, 0);
    chk("rst_rvalid_a0", rva0, 0);
    chk("rst_collision0", col0, 0);
    chk("rst_rdata_a1", rda1, 0);
    chk("rst_rvalid_b1", rvb1, 0);
    rst = 1'b0;
    count_busy(n);
    chk("busy_len", n, EXP_BUSY);
    step();
`ifdef DP_PRIO_BRAM_MEM_CLEAR_EN
    for (int i = 0; i < 16; i++) begin
      ra0 = mk(0, 1, AW'(i), '0, '0); push(0, '0); step();
    end
`endif
    // Collision with B priority, A read-first
    ra0 = mk(1, 0, 5, C11, 9'h1FF); step();
    ra0 = mk(1, 1, 5, CAA, 9'h1FF); rb0 = mk(1, 0, 5, CBB, 9'h1FF); push(0, C11); step();
    chk("collision_pulse", col0, 1);
    step();
    chk("collision_clear", col0, 0);
    ra0 = mk(0, 1, 5, '0, '0); push(0, CBB); step();
    // Byte merge across ports
    rb0 = mk(1, 0, 3, {9{8'hFF}}, 9'h001); ra0 = mk(1, 0, 3, '0, 9'h1FF); step();
    ra0 = mk(0, 1, 3, '0, '0); push(0, 72'hFF); step();
    // B write-first, A read-first with partial write
    rb0 = mk(1, 1, 7, 72'h123, 9'h1FF); push(1, 72'h123); step();
    ra0 = mk(1, 1, 7, 72'h456, 9'h001); push(0, 72'h123); step();
    rb0 = mk(0, 1, 7, '0, '0); push(1, 72'h156); step();
    // Cross-port read returns old word
    ra0 = mk(1, 0, 9, C99, 9'h1FF); step();
    rb0 = mk(1, 0, 9, 72'h77, 9'h1FF); ra0 = mk(0, 1, 9, '0, '0); push(0, C99); step();
    repeat (3) step();
    chk("hold_rdata_a0", rda0, C99);
    // Both ports read+write same address
    ra0 = mk(1, 0, 2, '0, 9'h1FF); step();
    ra0 = mk(1, 1, 2, CAA, 9'h1FF); rb0 = mk(1, 1, 2, 72'hBB, 9'h001);
    push(0, '0); push(1, {{8{8'hAA}}, 8'hBB}); step();
    // u1: cross-new, no-change, two-stage output
    ra1 = mk(1, 0, 9, C11, 9'h1FF); step();
    rb1 = mk(1, 0, 9, 72'h5A, 9'h1FF); ra1 = mk(0, 1, 9, '0, '0); push(2, 72'h5A); step();
    rb1 = mk(0, 1, 9, '0, '0); push(3, 72'h5A); step();
    repeat (2) step();
    rb1 = mk(1, 1, 4, 72'h77, 9'h1FF); step();
    repeat (3) step();
    chk("nochange_hold_b1", {rvb1, rdb1}, {1'b0, 72'h5A});
    ra1 = mk(0, 1, 9, '0, '0); push(2, 72'h5A); step();
    ra1 = mk(0, 1, 4, '0, '0); push(2, 72'h77); step();
    ra1 = mk(0, 1, 9, '0, '0); push(2, 72'h5A); step();
    repeat (3) step();
    // Reset discards in-flight read
    ra1 = mk(0, 1, 4, '0, '0); step();
    rst = 1'b1; step();
    rst = 1'b0;
    chk("rst_flush_rdata_a1", rda1, 0);
    repeat (4) step();
    chk("rst_flush_hold_a1", {rva1, rda1}, 0);
`ifdef DP_PRIO_BRAM_MEM_CLEAR_EN
    count_busy(n);
    rst = 1'b1; step(); rst = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    count_busy(n);
    chk("busy_restart_len", n, 16);
`endif
    repeat (4) step();
    chk("pending_q0a", q0a.size(), 0);
    chk("pending_q0b", q0b.size(), 0);
    chk("pending_q1a", q1a.size(), 0);
    chk("pending_q1b", q1b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
